// File: rtl/apb_accum_pkg.sv
// Shared types and register layout for the APB accumulator array.
// Offsets are word indices within a 16-byte channel window.
package apb_accum_pkg;

  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_ADD = 2'b11
  } op_e;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_CTRL = 2'd1;
  localparam logic [1:0] REG_RES  = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_CLEAR = 1;
  localparam int CTRL_MODE  = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_OVF  = 1;
  localparam int STAT_DONE = 2;

endpackage

// File: rtl/accum_channel.sv
// One accumulator channel: DATA/CONTROL/RESULT/STATUS registers,
// latency counter and ALU. Writes arrive only when the channel is idle.
module accum_channel
  import apb_accum_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ACC_LAT = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_i,
  input  logic [1:0]        reg_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int CW = $clog2(ACC_LAT + 1);

  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [DATA_W-1:0] snap_q, snap_d;
  op_e               mode_q, mode_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [DATA_W-1:0] alu;
  logic              carry;
  logic              expire;
  op_e               wmode;

  assign wmode  = op_e'(wdata_i[CTRL_MODE+1:CTRL_MODE]);
  assign expire = busy_q && (cnt_q == CW'(1));

  always_comb begin
    carry = 1'b0;
    alu   = '0;
    unique case (mode_q)
      OP_OR:  alu = res_q | snap_q;
      OP_AND: alu = res_q & snap_q;
      OP_XOR: alu = res_q ^ snap_q;
      OP_ADD: {carry, alu} = {1'b0, res_q} + {1'b0, snap_q};
    endcase
  end

  always_comb begin
    data_d = data_q;
    res_d  = res_q;
    snap_d = snap_q;
    mode_d = mode_q;
    busy_d = busy_q;
    ovf_d  = ovf_q;
    done_d = done_q;
    cnt_d  = cnt_q;
    if (wr_i) begin
      unique case (reg_i)
        REG_DATA: data_d = wdata_i;
        REG_CTRL: begin
          mode_d = wmode;
          if (wdata_i[CTRL_CLEAR]) begin
            res_d = (wmode == OP_AND) ? '1 : '0;
            ovf_d = 1'b0;
          end else if (wdata_i[CTRL_START]) begin
            snap_d = data_q;
            busy_d = 1'b1;
            cnt_d  = CW'(ACC_LAT);
          end
        end
        REG_STAT: if (wdata_i[STAT_DONE]) done_d = 1'b0;
        default: ;
      endcase
    end
    // completion comes last so a same-cycle W1C loses to the set
    if (busy_q) begin
      cnt_d = cnt_q - CW'(1);
      if (expire) begin
        res_d  = alu;
        busy_d = 1'b0;
        done_d = 1'b1;
        if (mode_q == OP_ADD && carry) ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      res_q  <= '0;
      snap_q <= '0;
      mode_q <= OP_OR;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      res_q  <= res_d;
      snap_q <= snap_d;
      mode_q <= mode_d;
      busy_q <= busy_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    unique case (reg_i)
      REG_DATA: rdata_o = data_q;
      REG_CTRL: rdata_o[CTRL_MODE+1:CTRL_MODE] = mode_q;
      REG_RES:  rdata_o = res_q;
      REG_STAT: begin
        rdata_o[STAT_BUSY] = busy_q;
        rdata_o[STAT_OVF]  = ovf_q;
        rdata_o[STAT_DONE] = done_q;
      end
    endcase
  end

  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: rtl/apb_accum_array.sv
// APB3 slave front end: address decode, per-channel stall and
// the PREADY/PRDATA/PSLVERR response mux over N_CH accumulators.
module apb_accum_array
  import apb_accum_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int N_CH    = 4,
  parameter int ACC_LAT = 3
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [N_CH-1:0]   irq_o
);

  logic [ADDR_W-5:0]            ch;
  logic [1:0]                   rsel;
  logic [N_CH-1:0][DATA_W-1:0]  ch_rdata;
  logic [N_CH-1:0]              ch_busy;
  logic [N_CH-1:0]              ch_done;
  logic [N_CH-1:0]              ch_hit;
  logic [N_CH-1:0]              ch_wr;
  logic [DATA_W-1:0]            sel_rdata;
  logic                         sel_busy;
  logic                         ch_ok;
  logic                         access;
  logic                         addr_err;
  logic                         stall;
  logic                         err;
  logic                         done_ok;

  assign ch     = PADDR[ADDR_W-1:4];
  assign rsel   = PADDR[3:2];
  assign access = PSEL & PENABLE;

  always_comb begin
    ch_hit    = '0;
    ch_ok     = 1'b0;
    sel_busy  = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (int'(ch) == i) begin
        ch_hit[i] = 1'b1;
        ch_ok     = 1'b1;
        sel_busy  = ch_busy[i];
        sel_rdata = ch_rdata[i];
      end
    end
  end

  assign addr_err = (PADDR[1:0] != 2'b00) | ~ch_ok;
  assign stall    = access & ~addr_err & sel_busy;
  assign err      = access & ~stall &
                    (addr_err | (PWRITE & (rsel == REG_RES)));
  assign done_ok  = access & ~stall & ~err;

  assign PREADY  = ~stall;
  assign PSLVERR = err;
  assign PRDATA  = (done_ok & ~PWRITE) ? sel_rdata : '0;
  assign ch_wr   = (done_ok & PWRITE) ? ch_hit : '0;
  assign irq_o   = ch_done;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    accum_channel #(
      .DATA_W  (DATA_W),
      .ACC_LAT (ACC_LAT)
    ) u_ch (
      .clk_i   (PCLK),
      .rst_ni  (PRESETn),
      .wr_i    (ch_wr[g]),
      .reg_i   (rsel),
      .wdata_i (PWDATA),
      .rdata_o (ch_rdata[g]),
      .busy_o  (ch_busy[g]),
      .done_o  (ch_done[g])
    );
  end

endmodule

// File: tb/tb_apb_accum_array.sv
// Scoreboard bench for apb_accum_array: expected responses are queued
// when each APB transfer is launched and checked when it completes.
module tb_apb_accum_array;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [3:0]  irq;

  typedef struct {
    logic        rd;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   w;

  always #5 clk = ~clk;

  apb_accum_array #(
    .DATA_W  (32),
    .ADDR_W  (8),
    .N_CH    (4),
    .ACC_LAT (3)
  ) dut (
    .PCLK    (clk),
    .PRESETn (rst_n),
    .PSEL    (psel),
    .PENABLE (penable),
    .PWRITE  (pwrite),
    .PADDR   (paddr),
    .PWDATA  (pwdata),
    .PRDATA  (prdata),
    .PREADY  (pready),
    .PSLVERR (pslverr),
    .irq_o   (irq)
  );

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic xfer(input logic wr, input logic [7:0] a,
                      input logic [31:0] wd, input logic [31:0] ed,
                      input logic ee, output int waits);
    exp_t e;
    e.rd = ~wr;
    e.data = ed;
    e.err = ee;
    sbq.push_back(e);
    @(posedge clk) #1;
    psel = 1'b1;
    penable = 1'b0;
    pwrite = wr;
    paddr = a;
    pwdata = wd;
    @(posedge clk) #1;
    penable = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (pready) break;
      waits++;
      if (waits > 50) begin
        check($sformatf("timeout@%h", a), 32'd0, 32'd1);
        break;
      end
    end
    e = sbq.pop_front();
    check($sformatf("%s@%h slverr", wr ? "wr" : "rd", a),
          {31'd0, pslverr}, {31'd0, e.err});
    if (e.rd) check($sformatf("rd@%h data", a), prdata, e.data);
    @(posedge clk) #1;
    psel = 1'b0;
    penable = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d,
                    input logic ee = 1'b0);
    int wt;
    xfer(1'b1, a, d, 32'd0, ee, wt);
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] ed,
                    input logic ee = 1'b0);
    int wt;
    xfer(1'b0, a, 32'd0, ed, ee, wt);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    @(negedge clk);
    check("rst pready", {31'd0, pready}, 32'd1);
    check("rst irq", {28'd0, irq}, 32'd0);
    check("rst prdata", prdata, 32'd0);
    rd(8'h00, 32'h0);
    rd(8'h04, 32'h0);
    rd(8'h08, 32'h0);
    rd(8'h0C, 32'h0);

    // ch0 OR with stall on RESULT read
    wr(8'h00, 32'h0C);
    wr(8'h04, 32'h1);
    xfer(1'b0, 8'h08, 32'd0, 32'h0000000C, 1'b0, w);
    check("ch0 stalled", {31'd0, w > 0}, 32'd1);
    check("ch0 stall bound", {31'd0, w <= 3}, 32'd1);
    wr(8'h00, 32'hB0);
    wr(8'h04, 32'h1);
    rd(8'h08, 32'hBC);
    rd(8'h0C, 32'h4);
    check("irq0 set", {31'd0, irq[0]}, 32'd1);
    wr(8'h0C, 32'h4);
    rd(8'h0C, 32'h0);
    check("irq0 clr", {31'd0, irq[0]}, 32'd0);

    // ch1 ADD with wrap and overflow; ch0 not stalled meanwhile
    wr(8'h14, 32'hE);
    rd(8'h18, 32'h0);
    wr(8'h10, 32'hFFFFFFFF);
    wr(8'h14, 32'hD);
    rd(8'h18, 32'hFFFFFFFF);
    rd(8'h1C, 32'h4);
    wr(8'h10, 32'h2);
    wr(8'h14, 32'hD);
    xfer(1'b0, 8'h08, 32'd0, 32'hBC, 1'b0, w);
    check("ch0 no wait", w, 32'd0);
    rd(8'h18, 32'h1);
    rd(8'h1C, 32'h6);
    rd(8'h14, 32'hC);

    // ch2 AND, identity and clear-wins
    wr(8'h24, 32'h6);
    rd(8'h28, 32'hFFFFFFFF);
    wr(8'h20, 32'hF0F0F0F0);
    wr(8'h24, 32'h5);
    rd(8'h28, 32'hF0F0F0F0);
    wr(8'h24, 32'h7);
    xfer(1'b0, 8'h2C, 32'd0, 32'h4, 1'b0, w);
    check("ch2 clr no busy", w, 32'd0);
    rd(8'h28, 32'hFFFFFFFF);
    rd(8'h24, 32'h4);
    check("irq 1,2", {28'd0, irq}, 32'h6);

    // error responses leave state untouched
    wr(8'h08, 32'hFFFFFFFF, 1'b1);
    rd(8'h08, 32'hBC);
    wr(8'h40, 32'h12345678, 1'b1);
    rd(8'h40, 32'h0, 1'b1);
    rd(8'h01, 32'h0, 1'b1);
    wr(8'h01, 32'hFFFF, 1'b1);
    rd(8'h00, 32'hB0);

    // reset in the middle of an operation
    wr(8'h00, 32'h55);
    wr(8'h04, 32'h1);
    @(posedge clk) #1;
    rst_n = 1'b0;
    #1 check("async rst irq", {28'd0, irq}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("post rst irq", {28'd0, irq}, 32'd0);
    rd(8'h08, 32'h0);
    rd(8'h00, 32'h0);
    rd(8'h0C, 32'h0);
    rd(8'h1C, 32'h0);
    rd(8'h28, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
